// File: rtl/sd_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sd_responder_pkg
// Description : Shared types and constants for the SD block responder.
// Revision    : 1.0 - initial release
// ============================================================================
package sd_responder_pkg;

    typedef enum logic [3:0] {
        UNINIT,
        INIT,
        IDLE,
        R_OPEN,
        R_READY,
        R_BYTE_BUSY,
        W_OPEN,
        W_READY,
        W_BYTE_BUSY,
        ERR_HOLD
    } state_t;

    localparam int         c_BLOCK_BYTES = 512;
    localparam logic [7:0] c_IDLE_DATA   = 8'hFF;

endpackage
`default_nettype wire

// File: rtl/sd_resp_mem.sv
`default_nettype none
// ============================================================================
// Module      : sd_resp_mem
// Description : Single-port byte RAM, synchronous write, 1-cycle read latency.
// Revision    : 1.0 - initial release
// ============================================================================
module sd_resp_mem #(
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [7:0]        wdata,
    output logic [7:0]        rdata
);

    logic [7:0] r_mem [0:(1<<ADDR_W)-1];
    logic [7:0] r_rdata;

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[addr] <= wdata;
        end
        r_rdata <= r_mem[addr];
    end

    assign rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/sd_block_responder.sv
`default_nettype none
// ============================================================================
// Module      : sd_block_responder
// Description : Card-less SD SPI responder backed by an on-chip block store.
//               Define SD_RESPONDER_MULTI_BLOCK_EN for multi-block rollover.
// Revision    : 1.0 - initial release
// ============================================================================
module sd_block_responder #(
    parameter int          BLOCK_ADDR_W = 3,
    parameter logic [31:0] BASE_BLOCK   = 32'h0010_0000,
    parameter int          INIT_CYCLES  = 16,
    parameter int          OPEN_CYCLES  = 8,
    parameter int          BYTE_CYCLES  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        spi_rst,
    input  logic        spi_r_block,
    input  logic        spi_r_multi_block,
    input  logic        spi_r_byte,
    input  logic        spi_w_block,
    input  logic        spi_w_byte,
    input  logic [31:0] spi_block_addr,
    input  logic [7:0]  spi_data_in,
    output logic        spi_busy,
    output logic [7:0]  spi_data_out,
    output logic        spi_err,
    output logic        spi_crc_err
);

    import sd_responder_pkg::*;

    localparam int c_CNT_MAX = (INIT_CYCLES > OPEN_CYCLES)
                             ? ((INIT_CYCLES > BYTE_CYCLES) ? INIT_CYCLES : BYTE_CYCLES)
                             : ((OPEN_CYCLES > BYTE_CYCLES) ? OPEN_CYCLES : BYTE_CYCLES);
    localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);
    localparam int c_MEM_AW  = BLOCK_ADDR_W + 9;

    localparam logic [c_CNT_W-1:0] c_INIT_LOAD = c_CNT_W'(INIT_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_OPEN_LOAD = c_CNT_W'(OPEN_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_BYTE_LOAD = c_CNT_W'(BYTE_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);
    localparam logic [9:0]         c_IDX_END   = 10'(c_BLOCK_BYTES);
    localparam logic [9:0]         c_IDX_LAST  = 10'(c_BLOCK_BYTES - 1);
    localparam logic [9:0]         c_IDX_MAX   = 10'd1023;

    state_t                    r_state, w_state_next;
    logic [c_CNT_W-1:0]        r_cnt, w_cnt_next;
    logic [9:0]                r_index, w_index_next;
    logic [BLOCK_ADDR_W-1:0]   r_blk, w_blk_next;
    logic [7:0]                r_data_out, w_data_next;
    logic                      r_err, w_err_next;
    logic                      r_sess_multi, w_multi_next;
    logic                      r_open_err, w_open_err_next;
    logic                      r_rst_armed, w_armed_next;

    logic [31:0] w_off;
    logic        w_addr_bad;
    logic        w_rst_take;
    logic        w_rd_req;
    logic        w_wr_state;
    logic        w_sess_line;
    logic        w_cnt_done;
    logic        w_roll;
    logic        w_mem_we;
    logic [7:0]  w_mem_rdata;

    assign w_off       = spi_block_addr - BASE_BLOCK;
    assign w_addr_bad  = |w_off[31:BLOCK_ADDR_W];
    // A held spi_rst must be seen low before it can restart initialisation.
    assign w_rst_take  = spi_rst && r_rst_armed;
    assign w_rd_req    = spi_r_block || spi_r_multi_block;
    assign w_wr_state  = (r_state inside {W_OPEN, W_READY, W_BYTE_BUSY});
    assign w_sess_line = w_wr_state ? spi_w_block
                       : (r_sess_multi ? spi_r_multi_block : spi_r_block);
    assign w_cnt_done  = (r_cnt == '0);

`ifdef SD_RESPONDER_MULTI_BLOCK_EN
    assign w_roll = r_sess_multi && (r_index == c_IDX_LAST);
`else
    assign w_roll = 1'b0;
`endif

    always_comb begin
        w_state_next    = r_state;
        w_cnt_next      = r_cnt;
        w_index_next    = r_index;
        w_blk_next      = r_blk;
        w_data_next     = r_data_out;
        w_err_next      = r_err;
        w_multi_next    = r_sess_multi;
        w_open_err_next = r_open_err;
        w_armed_next    = r_rst_armed | ~spi_rst;
        w_mem_we        = 1'b0;

        if (w_rst_take) begin
            w_state_next    = INIT;
            w_cnt_next      = c_INIT_LOAD;
            w_index_next    = '0;
            w_data_next     = c_IDLE_DATA;
            w_err_next      = 1'b0;
            w_open_err_next = 1'b0;
            w_armed_next    = 1'b0;
        end else begin
            case (r_state)
                UNINIT: begin
                    if (spi_w_block || w_rd_req) w_err_next = 1'b1;
                end
                INIT: begin
                    if (w_cnt_done) w_state_next = IDLE;
                    else            w_cnt_next   = r_cnt - c_CNT_ONE;
                end
                IDLE: begin
                    if (spi_w_block || w_rd_req) begin
                        w_state_next    = spi_w_block ? W_OPEN : R_OPEN;
                        w_multi_next    = !spi_w_block && spi_r_multi_block;
                        w_cnt_next      = c_OPEN_LOAD;
                        w_index_next    = '0;
                        w_blk_next      = w_off[BLOCK_ADDR_W-1:0];
                        w_data_next     = c_IDLE_DATA;
                        w_open_err_next = w_addr_bad;
                        if (w_addr_bad) w_err_next = 1'b1;
                    end
                end
                R_OPEN, W_OPEN: begin
                    if (!w_cnt_done)         w_cnt_next   = r_cnt - c_CNT_ONE;
                    else if (r_open_err)     w_state_next = ERR_HOLD;
                    else if (!w_sess_line)   w_state_next = IDLE;
                    else if (r_state == R_OPEN) begin
                        w_state_next = R_READY;
                        w_data_next  = w_mem_rdata;
                    end else                 w_state_next = W_READY;
                end
                R_READY: begin
                    if (!w_sess_line) begin
                        w_state_next = IDLE;
                    end else if (spi_r_byte) begin
                        w_state_next = R_BYTE_BUSY;
                        w_cnt_next   = c_BYTE_LOAD;
                        // Rolling past the last stored block parks the index at the end.
                        if (w_roll) begin
                            w_index_next = '0;
                            w_blk_next   = r_blk + 1'b1;
                            if (&r_blk) begin
                                w_err_next   = 1'b1;
                                w_index_next = c_IDX_END;
                                w_blk_next   = r_blk;
                            end
                        end else if (r_index < c_IDX_END) begin
                            w_index_next = r_index + 10'd1;
                        end
                    end
                end
                R_BYTE_BUSY: begin
                    if (!w_cnt_done) begin
                        w_cnt_next = r_cnt - c_CNT_ONE;
                    end else begin
                        w_data_next  = (r_index >= c_IDX_END) ? c_IDLE_DATA : w_mem_rdata;
                        w_state_next = w_sess_line ? R_READY : IDLE;
                    end
                end
                W_READY: begin
                    if (!w_sess_line) begin
                        w_state_next = IDLE;
                    end else if (spi_w_byte) begin
                        w_state_next = W_BYTE_BUSY;
                        w_cnt_next   = c_BYTE_LOAD;
                    end
                end
                W_BYTE_BUSY: begin
                    if (!w_cnt_done) begin
                        w_cnt_next = r_cnt - c_CNT_ONE;
                    end else begin
                        // Slots past the data block carry CRC/token bytes and are dropped.
                        w_mem_we     = (r_index < c_IDX_END);
                        w_index_next = (r_index == c_IDX_MAX) ? r_index : r_index + 10'd1;
                        w_state_next = w_sess_line ? W_READY : IDLE;
                    end
                end
                ERR_HOLD: begin
                    if (!(spi_w_block || w_rd_req)) w_state_next = IDLE;
                end
                default: w_state_next = UNINIT;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= UNINIT;
            r_cnt        <= '0;
            r_index      <= '0;
            r_blk        <= '0;
            r_data_out   <= c_IDLE_DATA;
            r_err        <= 1'b0;
            r_sess_multi <= 1'b0;
            r_open_err   <= 1'b0;
            r_rst_armed  <= 1'b1;
        end else begin
            r_state      <= w_state_next;
            r_cnt        <= w_cnt_next;
            r_index      <= w_index_next;
            r_blk        <= w_blk_next;
            r_data_out   <= w_data_next;
            r_err        <= w_err_next;
            r_sess_multi <= w_multi_next;
            r_open_err   <= w_open_err_next;
            r_rst_armed  <= w_armed_next;
        end
    end

    sd_resp_mem #(
        .ADDR_W (c_MEM_AW)
    ) u_mem (
        .clk   (clk),
        .we    (w_mem_we),
        .addr  ({r_blk, r_index[8:0]}),
        .wdata (spi_data_in),
        .rdata (w_mem_rdata)
    );

    assign spi_busy     = (r_state inside {INIT, R_OPEN, W_OPEN, R_BYTE_BUSY, W_BYTE_BUSY});
    assign spi_data_out = r_data_out;
    assign spi_err      = r_err;
    assign spi_crc_err  = 1'b0;

endmodule
`default_nettype wire
